// File: rtl/wr_bank_1x64b_to_40x64b_pkg.sv
// Geometry and merge helpers shared by the 40x64b write bank and the 40:1 read mux.
package wr_bank_1x64b_to_40x64b_pkg;

   localparam int NUM_ENTRIES = 40;
   localparam int ENTRY_W     = 64;
   localparam int SEL_W       = 6;
   localparam int FLAT_W      = NUM_ENTRIES * ENTRY_W;

   typedef logic [ENTRY_W-1:0]     entry_t;
   typedef logic [SEL_W-1:0]       sel_t;
   typedef logic [NUM_ENTRIES-1:0] valid_t;

   typedef struct packed {
      sel_t   sel;
      entry_t data;
      entry_t mask;
   } wr_req_t;

   // Bits with mask=1 take the new data; the rest keep the current value.
   function automatic entry_t merge_masked(entry_t cur, entry_t data, entry_t mask);
      return (cur & ~mask) | (data & mask);
   endfunction

   function automatic logic sel_in_range(sel_t sel);
      return sel < sel_t'(NUM_ENTRIES);
   endfunction

endpackage

// File: rtl/wr_bank_1x64b_to_40x64b_if.sv
// Write-request and entry-bus bundle between a bank driver and the 40x64b write bank.
interface wr_bank_1x64b_to_40x64b_if;
   import wr_bank_1x64b_to_40x64b_pkg::*;

   logic              wr_en;
   sel_t              wr_select;
   entry_t            wr_data;
   entry_t            wr_mask;
   logic              clr_en;
   logic              err_clr;
   logic [FLAT_W-1:0] out;
   valid_t            valid;
   logic              wr_ack;
   logic              err_oor;

   modport master (
      output wr_en, wr_select, wr_data, wr_mask, clr_en, err_clr,
      input  out, valid, wr_ack, err_oor
   );

   modport slave (
      input  wr_en, wr_select, wr_data, wr_mask, clr_en, err_clr,
      output out, valid, wr_ack, err_oor
   );

endinterface

// File: rtl/wr_bank_1x64b_to_40x64b_masked_reg.sv
// One 64-bit bank entry with sync clear and bit-masked write.
// Latency: 1 cycle from write/clear to q.
// Backpressure: none; every write and clear is taken on the edge it is sampled.
module masked_reg_64b
   import wr_bank_1x64b_to_40x64b_pkg::*;
(
   input  logic   clk,
   input  logic   rst_n,
   input  logic   clr,
   input  logic   we,
   input  entry_t data,
   input  entry_t mask,
   output entry_t q
);

   entry_t base;

   // A clear in the same cycle as a write zeroes first, so the write merges onto 0.
   assign base = clr ? '0 : q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         q <= '0;
      end else if (we) begin
         q <= merge_masked(base, data, mask);
      end else if (clr) begin
         q <= '0;
      end
   end

endmodule

// File: rtl/wr_bank_1x64b_to_40x64b.sv
// 40-entry x 64-bit masked write bank presenting all entries flat to the 40:1 read mux.
// Latency: 1 cycle write to out/valid; wr_ack pulses the cycle after an accepted write.
// Backpressure: none; one write per cycle, out-of-range selects dropped and flagged sticky.
module wr_bank_1x64b_to_40x64b
   import wr_bank_1x64b_to_40x64b_pkg::*;
(
   input logic clk,
   input logic rst_n,
   wr_bank_1x64b_to_40x64b_if.slave bus
);

   wr_req_t           req;
   logic              in_range;
   logic              accept;
   logic              reject;
   valid_t            we_vec;
   valid_t            valid_q;
   logic              ack_q;
   logic              err_q;
   logic [FLAT_W-1:0] out_flat;

   assign req      = '{sel: bus.wr_select, data: bus.wr_data, mask: bus.wr_mask};
   assign in_range = sel_in_range(req.sel);
   assign accept   = bus.wr_en &  in_range;
   assign reject   = bus.wr_en & ~in_range;

   always_comb begin
      we_vec = '0;
      for (int i = 0; i < NUM_ENTRIES; i++) begin
         we_vec[i] = accept && (req.sel == sel_t'(i));
      end
   end

   for (genvar g = 0; g < NUM_ENTRIES; g++) begin : g_entry
      masked_reg_64b u_reg (
         .clk   (clk),
         .rst_n (rst_n),
         .clr   (bus.clr_en),
         .we    (we_vec[g]),
         .data  (req.data),
         .mask  (req.mask),
         .q     (out_flat[g*ENTRY_W +: ENTRY_W])
      );
   end

   // valid marks an entry touched even by an all-zero mask; a new error beats err_clr.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         valid_q <= '0;
         ack_q   <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         valid_q <= (bus.clr_en ? '0 : valid_q) | we_vec;
         ack_q   <= accept;
         err_q   <= reject | (err_q & ~bus.err_clr);
      end
   end

   assign bus.out     = out_flat;
   assign bus.valid   = valid_q;
   assign bus.wr_ack  = ack_q;
   assign bus.err_oor = err_q;

endmodule

// File: tb/tb_wr_bank_1x64b_to_40x64b.sv
// Directed and randomized checks of the 40x64b write bank against an array-based reference model.
module tb_wr_bank_1x64b_to_40x64b;
   import wr_bank_1x64b_to_40x64b_pkg::*;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;

   wr_bank_1x64b_to_40x64b_if bus();

   wr_bank_1x64b_to_40x64b dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_fail   = 0;

   entry_t m_ent [NUM_ENTRIES];
   valid_t m_val;
   logic   m_ack;
   logic   m_err;

   function automatic logic [FLAT_W-1:0] model_flat();
      logic [FLAT_W-1:0] f;
      for (int i = 0; i < NUM_ENTRIES; i++) f[i*ENTRY_W +: ENTRY_W] = m_ent[i];
      return f;
   endfunction

   function automatic int first_diff(logic [FLAT_W-1:0] a, logic [FLAT_W-1:0] b);
      for (int i = 0; i < NUM_ENTRIES; i++)
         if (a[i*ENTRY_W +: ENTRY_W] !== b[i*ENTRY_W +: ENTRY_W]) return i;
      return 0;
   endfunction

   function automatic entry_t ent(logic [FLAT_W-1:0] f, int idx);
      return f[idx*ENTRY_W +: ENTRY_W];
   endfunction

   function automatic entry_t rnd64();
      return {$urandom, $urandom};
   endfunction

   task automatic model_reset();
      for (int i = 0; i < NUM_ENTRIES; i++) m_ent[i] = '0;
      m_val = '0;
      m_ack = 1'b0;
      m_err = 1'b0;
   endtask

   task automatic model_step(input logic we, input int sel, input entry_t data,
                             input entry_t mask, input logic clr, input logic eclr);
      m_ack = 1'b0;
      if (clr) begin
         for (int i = 0; i < NUM_ENTRIES; i++) m_ent[i] = '0;
         m_val = '0;
      end
      if (we && sel < NUM_ENTRIES) begin
         for (int b = 0; b < ENTRY_W; b++)
            if (mask[b]) m_ent[sel][b] = data[b];
         m_val[sel] = 1'b1;
         m_ack = 1'b1;
      end
      if (we && sel >= NUM_ENTRIES) m_err = 1'b1;
      else if (eclr)                m_err = 1'b0;
   endtask

   task automatic idle();
      bus.wr_en     = 1'b0;
      bus.wr_select = sel_t'($urandom_range(0, 63));
      bus.wr_data   = rnd64();
      bus.wr_mask   = rnd64();
      bus.clr_en    = 1'b0;
      bus.err_clr   = 1'b0;
   endtask

   // Drive at the falling edge, sample on the rising edge, return at the next falling edge.
   task automatic cycle(input logic we, input int sel, input entry_t data,
                        input entry_t mask, input logic clr, input logic eclr);
      bus.wr_en     = we;
      bus.wr_select = sel_t'(sel);
      bus.wr_data   = data;
      bus.wr_mask   = mask;
      bus.clr_en    = clr;
      bus.err_clr   = eclr;
      @(posedge clk);
      model_step(we, sel, data, mask, clr, eclr);
      @(negedge clk);
      idle();
   endtask

   task automatic test_reset();
      logic [FLAT_W-1:0] zero_flat;
      zero_flat = '0;
      idle();
      model_reset();
      rst_n = 1'b0;
      repeat (3) @(negedge clk);
      n_checks++; if (bus.out !== zero_flat) begin n_fail++; $display("FAIL por_out: entry %0d got %h want 0", first_diff(bus.out, zero_flat), ent(bus.out, first_diff(bus.out, zero_flat))); end
      n_checks++; if (bus.valid !== '0) begin n_fail++; $display("FAIL por_valid: got %h want 0", bus.valid); end
      n_checks++; if (bus.wr_ack !== 1'b0) begin n_fail++; $display("FAIL por_ack: got %b want 0", bus.wr_ack); end
      n_checks++; if (bus.err_oor !== 1'b0) begin n_fail++; $display("FAIL por_err: got %b want 0", bus.err_oor); end
      rst_n = 1'b1;
      @(negedge clk);
      for (int i = 0; i < 6; i++) cycle(1'b1, $urandom_range(0, 39), rnd64(), rnd64(), 1'b0, 1'b0);
      cycle(1'b1, 50, rnd64(), '1, 1'b0, 1'b0);
      cycle(1'b1, $urandom_range(0, 39), rnd64() | 64'h1, '1, 1'b0, 1'b0);
      #2 rst_n = 1'b0;
      #1;
      n_checks++; if (bus.out !== zero_flat) begin n_fail++; $display("FAIL async_out: entry %0d got %h want 0", first_diff(bus.out, zero_flat), ent(bus.out, first_diff(bus.out, zero_flat))); end
      n_checks++; if (bus.valid !== '0) begin n_fail++; $display("FAIL async_valid: got %h want 0", bus.valid); end
      n_checks++; if (bus.wr_ack !== 1'b0) begin n_fail++; $display("FAIL async_ack: got %b want 0", bus.wr_ack); end
      n_checks++; if (bus.err_oor !== 1'b0) begin n_fail++; $display("FAIL async_err: got %b want 0", bus.err_oor); end
      model_reset();
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      // A write sampled while reset is asserted must be lost.
      bus.wr_en = 1'b1; bus.wr_select = 6'd9; bus.wr_data = '1; bus.wr_mask = '1;
      #2 rst_n = 1'b0;
      @(negedge clk);
      idle();
      rst_n = 1'b1;
      cycle(1'b0, 0, '0, '0, 1'b0, 1'b0);
      n_checks++; if (bus.valid !== '0) begin n_fail++; $display("FAIL lost_write_valid: got %h want 0", bus.valid); end
      n_checks++; if (ent(bus.out, 9) !== '0) begin n_fail++; $display("FAIL lost_write_out: got %h want 0", ent(bus.out, 9)); end
   endtask

   task automatic test_full_write();
      cycle(1'b1, 0, 64'hDEAD_BEEF_0123_4567, '1, 1'b0, 1'b0);
      n_checks++; if (bus.out[63:0] !== 64'hDEAD_BEEF_0123_4567) begin n_fail++; $display("FAIL full_e0: got %h want DEADBEEF01234567", bus.out[63:0]); end
      n_checks++; if (bus.valid !== 40'h1) begin n_fail++; $display("FAIL full_valid0: got %h want 0000000001", bus.valid); end
      n_checks++; if (bus.wr_ack !== 1'b1) begin n_fail++; $display("FAIL full_ack: got %b want 1", bus.wr_ack); end
      cycle(1'b0, 0, '0, '0, 1'b0, 1'b0);
      n_checks++; if (bus.wr_ack !== 1'b0) begin n_fail++; $display("FAIL full_ack_pulse: got %b want 0", bus.wr_ack); end
      cycle(1'b1, 39, '1, '1, 1'b0, 1'b0);
      n_checks++; if (bus.out[2559:2496] !== 64'hFFFF_FFFF_FFFF_FFFF) begin n_fail++; $display("FAIL full_e39: got %h want all ones", bus.out[2559:2496]); end
      n_checks++; if (bus.valid !== 40'h80_0000_0001) begin n_fail++; $display("FAIL full_valid39: got %h want 8000000001", bus.valid); end
      n_checks++; if (bus.out !== model_flat()) begin n_fail++; $display("FAIL full_out: entry %0d got %h want %h", first_diff(bus.out, model_flat()), ent(bus.out, first_diff(bus.out, model_flat())), ent(model_flat(), first_diff(bus.out, model_flat()))); end
   endtask

   task automatic test_masked_merge();
      n_checks++; if (bus.out[383:320] !== 64'h0) begin n_fail++; $display("FAIL merge_pre: got %h want 0", bus.out[383:320]); end
      cycle(1'b1, 5, 64'hFFFF_FFFF_FFFF_FFFF, 64'h0000_0000_FFFF_0000, 1'b0, 1'b0);
      n_checks++; if (bus.out[383:320] !== 64'h0000_0000_FFFF_0000) begin n_fail++; $display("FAIL merge_first: got %h want 00000000FFFF0000", bus.out[383:320]); end
      cycle(1'b1, 5, 64'h0, 64'h0000_0000_00FF_0000, 1'b0, 1'b0);
      n_checks++; if (bus.out[383:320] !== 64'h0000_0000_FF00_0000) begin n_fail++; $display("FAIL merge_second: got %h want 00000000FF000000", bus.out[383:320]); end
      cycle(1'b1, 20, rnd64(), 64'h0, 1'b0, 1'b0);
      n_checks++; if (bus.valid[20] !== 1'b1 || bus.out[20*64 +: 64] !== 64'h0) begin n_fail++; $display("FAIL merge_zero_mask: valid %b entry %h want valid 1 entry 0", bus.valid[20], bus.out[20*64 +: 64]); end
   endtask

   task automatic test_out_of_range();
      logic [FLAT_W-1:0] snap;
      valid_t            vsnap;
      snap  = model_flat();
      vsnap = m_val;
      n_checks++; if (bus.err_oor !== 1'b0) begin n_fail++; $display("FAIL oor_pre: got %b want 0", bus.err_oor); end
      cycle(1'b1, 40, rnd64(), '1, 1'b0, 1'b0);
      n_checks++; if (bus.out !== snap) begin n_fail++; $display("FAIL oor40_out: entry %0d got %h want %h", first_diff(bus.out, snap), ent(bus.out, first_diff(bus.out, snap)), ent(snap, first_diff(bus.out, snap))); end
      n_checks++; if (bus.valid !== vsnap) begin n_fail++; $display("FAIL oor40_valid: got %h want %h", bus.valid, vsnap); end
      n_checks++; if (bus.wr_ack !== 1'b0) begin n_fail++; $display("FAIL oor40_ack: got %b want 0", bus.wr_ack); end
      n_checks++; if (bus.err_oor !== 1'b1) begin n_fail++; $display("FAIL oor40_err: got %b want 1", bus.err_oor); end
      cycle(1'b1, 63, rnd64(), '1, 1'b0, 1'b0);
      n_checks++; if (bus.out !== snap || bus.valid !== vsnap) begin n_fail++; $display("FAIL oor63_state: valid %h want %h, entry %0d got %h", bus.valid, vsnap, first_diff(bus.out, snap), ent(bus.out, first_diff(bus.out, snap))); end
      n_checks++; if (bus.wr_ack !== 1'b0 || bus.err_oor !== 1'b1) begin n_fail++; $display("FAIL oor63_flags: ack %b err %b want ack 0 err 1", bus.wr_ack, bus.err_oor); end
      cycle(1'b1, 45, rnd64(), '1, 1'b0, 1'b1);
      n_checks++; if (bus.err_oor !== 1'b1) begin n_fail++; $display("FAIL oor_set_wins: got %b want 1", bus.err_oor); end
      cycle(1'b0, 0, '0, '0, 1'b0, 1'b1);
      n_checks++; if (bus.err_oor !== 1'b0) begin n_fail++; $display("FAIL oor_clear: got %b want 0", bus.err_oor); end
   endtask

   task automatic test_clear_write();
      logic [FLAT_W-1:0] exp_flat;
      for (int i = 0; i < NUM_ENTRIES; i++) cycle(1'b1, i, rnd64() | 64'h1, '1, 1'b0, 1'b0);
      n_checks++; if (bus.valid !== '1) begin n_fail++; $display("FAIL clrw_populated: got %h want all ones", bus.valid); end
      cycle(1'b1, 7, 64'h1234, '1, 1'b1, 1'b0);
      exp_flat = '0;
      exp_flat[511:448] = 64'h1234;
      n_checks++; if (bus.out !== exp_flat) begin n_fail++; $display("FAIL clrw_out: entry %0d got %h want %h", first_diff(bus.out, exp_flat), ent(bus.out, first_diff(bus.out, exp_flat)), ent(exp_flat, first_diff(bus.out, exp_flat))); end
      n_checks++; if (bus.valid !== 40'h80) begin n_fail++; $display("FAIL clrw_valid: got %h want 0000000080", bus.valid); end
      n_checks++; if (bus.wr_ack !== 1'b1) begin n_fail++; $display("FAIL clrw_ack: got %b want 1", bus.wr_ack); end
      cycle(1'b0, 0, '0, '0, 1'b1, 1'b0);
      n_checks++; if (bus.out !== '0 || bus.valid !== '0) begin n_fail++; $display("FAIL clr_only: valid %h want 0, entry 7 %h want 0", bus.valid, bus.out[511:448]); end
   endtask

   task automatic test_back_to_back();
      entry_t a, b, exp;
      a = rnd64();
      b = rnd64();
      exp = {b[63:32], a[31:0]};
      cycle(1'b1, 3, a, 64'h0000_0000_FFFF_FFFF, 1'b0, 1'b0);
      n_checks++; if (bus.wr_ack !== 1'b1) begin n_fail++; $display("FAIL b2b_ack1: got %b want 1", bus.wr_ack); end
      cycle(1'b1, 3, b, 64'hFFFF_FFFF_0000_0000, 1'b0, 1'b0);
      n_checks++; if (bus.wr_ack !== 1'b1) begin n_fail++; $display("FAIL b2b_ack2: got %b want 1", bus.wr_ack); end
      n_checks++; if (bus.out[255:192] !== exp) begin n_fail++; $display("FAIL b2b_merge: got %h want %h", bus.out[255:192], exp); end
      cycle(1'b0, 3, '0, '1, 1'b0, 1'b0);
      n_checks++; if (bus.wr_ack !== 1'b0) begin n_fail++; $display("FAIL b2b_ack_end: got %b want 0", bus.wr_ack); end
   endtask

   task automatic test_random();
      logic   we, clr, eclr;
      int     sel;
      entry_t mask;
      for (int n = 0; n < 400; n++) begin
         we   = ($urandom_range(0, 3) != 0);
         sel  = ($urandom_range(0, 7) == 0) ? $urandom_range(40, 63) : $urandom_range(0, 39);
         case ($urandom_range(0, 5))
            0:       mask = '0;
            1:       mask = '1;
            default: mask = rnd64();
         endcase
         clr  = ($urandom_range(0, 15) == 0);
         eclr = ($urandom_range(0, 7) == 0);
         cycle(we, sel, rnd64(), mask, clr, eclr);
         n_checks++; if (bus.out !== model_flat()) begin n_fail++; $display("FAIL rnd_out[%0d]: entry %0d got %h want %h", n, first_diff(bus.out, model_flat()), ent(bus.out, first_diff(bus.out, model_flat())), ent(model_flat(), first_diff(bus.out, model_flat()))); end
         n_checks++; if (bus.valid !== m_val) begin n_fail++; $display("FAIL rnd_valid[%0d]: got %h want %h", n, bus.valid, m_val); end
         n_checks++; if (bus.wr_ack !== m_ack) begin n_fail++; $display("FAIL rnd_ack[%0d]: got %b want %b", n, bus.wr_ack, m_ack); end
         n_checks++; if (bus.err_oor !== m_err) begin n_fail++; $display("FAIL rnd_err[%0d]: got %b want %b", n, bus.err_oor, m_err); end
      end
   endtask

   initial begin
      test_reset();
      test_full_write();
      test_masked_merge();
      test_out_of_range();
      test_clear_write();
      test_back_to_back();
      test_random();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached, %0d checks done", n_checks);
      $fatal(1);
   end

endmodule
